// File: rtl/irq_request_latch.sv
// irq_request_latch: interrupt request front end for the 8-bit priority encoder.
// It synchronizes the request lines and latches each source by edge or by level.
// It tracks pending and in-service state and drives a registered request vector.
//
// Optional build macro: IRQ_NESTING_EN
//   defined   : in-service tracking, eoi and priority-threshold masking are active
//   undefined : in_service stays 0, eoi is ignored, req_vec = pending & mask
//
// Ports:
//   clk        : clock, all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//   irq_in     : asynchronous request lines (bit 7 = highest priority)
//   edge_sel   : per-source mode, 1 = rising-edge latched, 0 = level
//   mask       : per-source enable, 1 = enabled
//   ack_valid  : single-cycle acknowledge strobe
//   ack_id     : index of the acknowledged source
//   eoi        : single-cycle end-of-interrupt strobe
//   req_vec    : registered masked request vector to the encoder
//   pending    : raw pending register
//   in_service : in-service register
//   overrun    : per-source pulse, an edge was lost because pending was already set
//   ack_err    : pulse, the acknowledged source was not requesting
module irq_request_latch #(
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned N_SRC = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] irq_in,
  input  logic [N_SRC-1:0] edge_sel,
  input  logic [N_SRC-1:0] mask,
  input  logic             ack_valid,
  input  logic [2:0]       ack_id,
  input  logic             eoi,
  output logic [N_SRC-1:0] req_vec,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] in_service,
  output logic [N_SRC-1:0] overrun,
  output logic             ack_err
);

  // Newest sample enters at index 0; the synchronized value leaves at the top.
  logic [SYNC_STAGES-1:0][N_SRC-1:0] sync_q;
  logic [N_SRC-1:0] prev;

  logic [N_SRC-1:0] s;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] ack_hit;
  logic [N_SRC-1:0] pending_next;
  logic [N_SRC-1:0] overrun_next;
  logic [N_SRC-1:0] in_service_next;
  logic [N_SRC-1:0] thr_mask;
  logic             ack_ok;
  logic             ack_bad;

  // Edge detection, acknowledge qualification and pending update.
  always_comb begin
    s       = sync_q[SYNC_STAGES-1];
    rise    = s & ~prev;
    ack_ok  = ack_valid & req_vec[ack_id];
    ack_bad = ack_valid & ~req_vec[ack_id];
    ack_hit = '0;
    if (ack_ok) begin
      ack_hit[ack_id] = 1'b1;
    end
    // A new edge in the same cycle as its ack keeps the bit set.
    pending_next = (edge_sel & ((pending & ~ack_hit) | rise)) | (~edge_sel & s);
    overrun_next = edge_sel & rise & pending & ~ack_hit;
  end

`ifdef IRQ_NESTING_EN
  logic [N_SRC-1:0] eoi_clr;

  // Highest in-service bit sets the threshold and is the one eoi retires.
  always_comb begin
    eoi_clr  = '0;
    thr_mask = '1;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (in_service[i]) begin
        eoi_clr    = '0;
        eoi_clr[i] = 1'b1;
        thr_mask   = ~((N_SRC'(2) << i) - N_SRC'(1));
      end
    end
    in_service_next = in_service;
    if (eoi) begin
      in_service_next = in_service_next & ~eoi_clr;
    end
    // eoi clear uses the current state; the ack set lands on top of it.
    in_service_next = in_service_next | ack_hit;
  end
`else
  logic unused_eoi;
  assign unused_eoi = eoi;

  // Without nesting every pending, enabled source is presented.
  always_comb begin
    thr_mask        = '1;
    in_service_next = '0;
  end
`endif

  // State registers; req_vec trails pending/in_service by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      prev       <= '0;
      pending    <= '0;
      in_service <= '0;
      req_vec    <= '0;
      overrun    <= '0;
      ack_err    <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], irq_in};
      prev       <= s;
      pending    <= pending_next;
      in_service <= in_service_next;
      req_vec    <= pending & mask & thr_mask;
      overrun    <= overrun_next;
      ack_err    <= ack_bad;
    end
  end

endmodule
